fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h00000020, meaning the redirect target on exception.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port stall  input  1  meaning a downstream pipeline hold request.
REQ-006 SHALL have port branch_flag  input  1  meaning a taken branch or jump resolved in decode.
REQ-007 SHALL have port branch_target  input  32  meaning the branch destination address.
REQ-008 SHALL have port exc_flag  input  1  meaning an exception or flush request.
REQ-009 SHALL have port imem_ack  input  1  meaning instruction memory has returned the word at pc this cycle.
REQ-010 SHALL have port pc  output  32  meaning the current fetch address.
REQ-011 SHALL have port ce  output  1  meaning the instruction memory chip enable / fetch request.
REQ-012 SHALL have port flush  output  1  meaning a one-cycle pulse that invalidates the IF/ID register.

Function
REQ-013 SHALL implement the states IDLE, FETCH and DRAIN; IDLE is entered on reset and always exits to FETCH on the next edge.
REQ-014 IDLE SHALL drive ce=0, pc=RESET_PC and flush=0.
REQ-015 FETCH and DRAIN SHALL drive ce=1, holding pc stable until imem_ack.
REQ-016 In FETCH with imem_ack=1, no redirect and stall=0, pc SHALL become pc+4 at the next edge (1-cycle latency), with modulo-2^32 wrap (32'hFFFFFFFC -> 32'h0).
REQ-017 In FETCH with stall=1 and no exception, pc SHALL hold regardless of imem_ack.
REQ-018 Redirect priority SHALL be exc_flag (target EXC_VECTOR) over branch_flag (target branch_target); branch_flag SHALL be ignored while stall=1, and exc_flag SHALL be honoured regardless of stall.
REQ-019 A redirect in FETCH with imem_ack=1 SHALL load pc with the target at the next edge and assert flush for that one cycle.
REQ-020 A redirect in FETCH with imem_ack=0 SHALL capture the target in a pending register and move to DRAIN, leaving pc unchanged.
REQ-021 In DRAIN, a later exc_flag SHALL overwrite a pending branch target, and a later branch_flag SHALL be ignored.
REQ-022 In DRAIN with imem_ack=1, pc SHALL load the pending target, flush SHALL pulse for one cycle, and the state SHALL return to FETCH.
REQ-023 Every target loaded into pc SHALL have bits [1:0] forced to 2'b00.
REQ-024 flush SHALL be 0 in all cycles other than those defined in REQ-019 and REQ-022.

Reset
REQ-025 rst=0 at any edge, in any state including DRAIN, SHALL set state=IDLE, pc=RESET_PC, ce=0 and flush=0, and SHALL clear any pending redirect.
REQ-026 While rst=0, all inputs SHALL be ignored.

Configuration
REQ-027 With macro FETCH_EXC_EN defined, exc_flag SHALL behave as specified above.
REQ-028 With FETCH_EXC_EN undefined, exc_flag SHALL be ignored and the EXC_VECTOR logic SHALL be absent; branches SHALL behave identically in both builds.

Structure
REQ-029 State encodings and the RESET_PC/EXC_VECTOR defaults SHALL reside in the shared defines file.
REQ-030 The redirect priority/target selection SHALL be a combinational sub-module, fetch_redir_sel; the FSM, pc and pending registers SHALL be in fetch_ctrl.

Verification
REQ-031 Bench SHALL check: rst=0 for 2 cycles, then release -> ce=0 and pc=0 in IDLE, then ce=1; with imem_ack tied to 1, pc steps 0,4,8,C.
REQ-032 Bench SHALL check: with imem_ack=1, stall=1 for 3 cycles at pc=8 -> pc holds at 8 for those 3 cycles, then resumes at C.
REQ-033 Bench SHALL check: branch_flag=1, branch_target=32'h103 with imem_ack=1 -> next pc=32'h100, flush high for exactly 1 cycle.
REQ-034 Bench SHALL check: branch to 32'h200 while imem_ack=0 -> DRAIN; exc_flag one cycle later; imem_ack=1 two cycles later -> pc=32'h20, a single flush pulse.
REQ-035 Bench SHALL check: pc=32'hFFFFFFFC with imem_ack=1 -> pc=0; rst=0 while in DRAIN -> pc=RESET_PC, pending target discarded.
REQ-036 Bench SHALL check: build without FETCH_EXC_EN, pulse exc_flag=1 -> pc sequence unchanged and no flush.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding,
// default reset/exception addresses and the word-alignment helper.
package fetch_ctrl_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] PC_STEP        = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_e;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_redir_sel.sv
// Redirect priority and target selection for fetch_ctrl (combinational).
// Exception redirects exist only when FETCH_EXC_EN is defined.
module fetch_redir_sel
    import fetch_ctrl_pkg::*;
`ifdef FETCH_EXC_EN
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)
`endif
(
    input  logic        in_drain,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
`ifdef FETCH_EXC_EN
    input  logic        exc_flag,
`endif
    output logic        redir_valid,
    output logic [31:0] redir_target
);

    logic br_hit;

    // Branches are dropped under stall, and while draining a redirect is already owned.
    assign br_hit = branch_flag && !stall && !in_drain;

`ifdef FETCH_EXC_EN
    assign redir_valid  = exc_flag || br_hit;
    assign redir_target = word_align(exc_flag ? EXC_VECTOR : branch_target);
`else
    assign redir_valid  = br_hit;
    assign redir_target = word_align(branch_target);
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/DRAIN FSM, PC and pending-redirect registers.
// Define FETCH_EXC_EN to enable exception redirects to EXC_VECTOR.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        exc_flag,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic        ce,
    output logic        flush
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  pend_reg, pend_next;
    logic         flush_reg, flush_next;

    logic         redir_valid;
    logic [31:0]  redir_target;
    logic         in_drain;

    assign in_drain = (state_reg == ST_DRAIN);

`ifdef FETCH_EXC_EN
    fetch_redir_sel #(
        .EXC_VECTOR    (EXC_VECTOR)
    ) u_redir_sel (
        .in_drain      (in_drain),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .exc_flag      (exc_flag),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target)
    );
`else
    fetch_redir_sel u_redir_sel (
        .in_drain      (in_drain),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target)
    );

    // Sink for the exception input and vector, which have no function in this build.
    logic unused_exc;
    assign unused_exc = ^{exc_flag, EXC_VECTOR};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            pend_reg  <= '0;
            flush_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            pend_reg  <= pend_next;
            flush_reg <= flush_next;
        end
    end

    // flush is registered: it is high in the first cycle that pc shows a redirect target.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        pend_next  = pend_reg;
        flush_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (redir_valid) begin
                    if (imem_ack) begin
                        pc_next    = redir_target;
                        flush_next = 1'b1;
                    end else begin
                        pend_next  = redir_target;
                        state_next = ST_DRAIN;
                    end
                end else if (imem_ack && !stall) begin
                    pc_next = pc_reg + PC_STEP;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    pc_next    = redir_valid ? redir_target : pend_reg;
                    flush_next = 1'b1;
                    state_next = ST_FETCH;
                end else if (redir_valid) begin
                    pend_next = redir_target;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pc    = pc_reg;
    assign ce    = (state_reg != ST_IDLE);
    assign flush = flush_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic,
// all checked against a behavioural fetch model (exception path follows FETCH_EXC_EN).
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0020;
`ifdef FETCH_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        exc_flag = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] pc;
    logic        ce;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: running flag, current pc, optional pending redirect, flush pulse.
    bit          m_run = 1'b0;
    logic [31:0] m_pc = RST_PC;
    bit          m_pend_v = 1'b0;
    logic [31:0] m_pend_t = '0;
    bit          m_flush = 1'b0;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .exc_flag      (exc_flag),
        .imem_ack      (imem_ack),
        .pc            (pc),
        .ce            (ce),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        bit          exc_on;
        m_flush = 1'b0;
        exc_on  = EXC_EN && exc_flag;
        if (!rst) begin
            m_run    = 1'b0;
            m_pc     = RST_PC;
            m_pend_v = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (!m_pend_v) begin
            if (exc_on || (branch_flag && !stall)) begin
                tgt = exc_on ? EXC_VEC : branch_target;
                tgt = {tgt[31:2], 2'b00};
                if (imem_ack) begin
                    m_pc    = tgt;
                    m_flush = 1'b1;
                end else begin
                    m_pend_v = 1'b1;
                    m_pend_t = tgt;
                end
            end else if (imem_ack && !stall) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (exc_on) m_pend_t = EXC_VEC;
            if (imem_ack) begin
                m_pc     = m_pend_t;
                m_flush  = 1'b1;
                m_pend_v = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t,
                        input logic e, input logic a);
        rst = r; stall = s; branch_flag = b; branch_target = t; exc_flag = e; imem_ack = a;
        model_edge();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b stall=%b br=%b bt=%h exc=%b ack=%b -> pc=%h ce=%b flush=%b",
                 $time, r, s, b, t, e, a, pc, ce, flush);
        check("pc", pc, m_pc);
        check("ce", {31'd0, ce}, {31'd0, m_run});
        check("flush", {31'd0, flush}, {31'd0, m_flush});
    endtask

    initial begin
        logic [31:0] rt;
        // Reset for two cycles, then IDLE -> FETCH and sequential fetch
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("idle_ce", {31'd0, ce}, 32'd0);
        check("idle_pc", pc, 32'h0);
        step(1, 0, 0, 0, 0, 1);
        check("fetch_ce", {31'd0, ce}, 32'd1);
        check("seq_pc0", pc, 32'h0);
        step(1, 0, 0, 0, 0, 1);
        check("seq_pc4", pc, 32'h4);
        step(1, 0, 0, 0, 0, 1);
        check("seq_pc8", pc, 32'h8);
        // Stall holds pc at 8 for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 1);
            check("stall_hold", pc, 32'h8);
        end
        step(1, 0, 0, 0, 0, 1);
        check("seq_pcC", pc, 32'hC);
        step(1, 0, 0, 0, 0, 1);
        // Branch with ack: aligned target, single flush pulse
        step(1, 0, 1, 32'h103, 0, 1);
        check("br_pc", pc, 32'h100);
        check("br_flush", {31'd0, flush}, 32'd1);
        step(1, 0, 0, 0, 0, 0);
        check("br_flush_end", {31'd0, flush}, 32'd0);
        // Branch without ack -> drain; exception one cycle later; ack two cycles after that
        step(1, 0, 1, 32'h200, 0, 0);
        check("drain_hold", pc, 32'h100);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        check("drain_no_flush", {31'd0, flush}, 32'd0);
        step(1, 0, 0, 0, 0, 1);
        check("drain_pc", pc, EXC_EN ? 32'h20 : 32'h200);
        check("drain_flush", {31'd0, flush}, 32'd1);
        step(1, 0, 0, 0, 0, 0);
        check("drain_flush_end", {31'd0, flush}, 32'd0);
        // Wrap at the top of the address space
        step(1, 0, 1, 32'hFFFF_FFFC, 0, 1);
        check("top_pc", pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 1);
        check("wrap_pc", pc, 32'h0);
        // Reset while draining discards the pending target
        step(1, 0, 1, 32'h300, 0, 0);
        step(0, 0, 1, 32'h400, 1, 1);
        check("rst_drain_pc", pc, RST_PC);
        check("rst_drain_ce", {31'd0, ce}, 32'd0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("rst_discard_pc", pc, 32'h4);
        check("rst_discard_flush", {31'd0, flush}, 32'd0);
        // Exception pulse: redirect only when the exception path is built in
        step(1, 0, 0, 0, 1, 1);
        check("exc_pc", pc, EXC_EN ? 32'h20 : 32'h8);
        check("exc_flush", {31'd0, flush}, EXC_EN ? 32'd1 : 32'd0);
        step(1, 0, 0, 0, 0, 1);
        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), rt,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
